// File: rtl/exe_muldiv_pkg.sv
// Shared decode constants and state encoding for the EXE-stage HI/LO
// multiply/divide unit (exe_muldiv and muldiv_datapath).
package exe_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [MD_WIDTH-1:0] DIV0_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 iterative engine: 2W-bit accumulator, shift-add multiply and
// restoring shift-subtract divide on unsigned operands.
// Ports: clock, reset (sync, active-low), op_div, load, step,
//        a/b (unsigned operands, sampled on load), res (raw result).
// res: multiply -> product; divide -> {remainder, quotient}.
module muldiv_datapath
    import exe_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               op_div,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] res
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opb;
    logic               div_mode;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   dsub;
    logic               fits;

    // Multiply: low half holds the unconsumed multiplier bits, high half
    // the partial product; both shift right together each step.
    // Divide: low half holds dividend bits being shifted into the partial
    // remainder (high half) while quotient bits enter from the right.
    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        rem  = acc[2*WIDTH-1:WIDTH-1];
        fits = rem >= {1'b0, opb};
        dsub = rem[WIDTH-1:0] - opb;
        if (div_mode) begin
            if (fits)
                acc_nxt = {dsub, acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_nxt = {sum, acc[WIDTH-1:1]};
            else
                acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc      <= '0;
            opb      <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, a};
            opb      <= b;
            div_mode <= op_div;
        end else if (step) begin
            acc      <= acc_nxt;
        end
    end

    assign res = acc;

endmodule

// File: rtl/exe_muldiv.sv
// EXE-stage HI/LO unit: MULT/MULTU/DIV/DIVU over WIDTH+1 cycles, MFHI/MFLO/
// MTHI/MTLO, and a stall request while a HI/LO access meets a busy unit.
// Ports: clock, reset (sync, active-low), ins_ID_EXE, a_ID_EXE, b_ID_EXE,
//        stall_req, busy, hilo_sel, hilo_rdata.
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ins_ID_EXE,
    input  logic [WIDTH-1:0] a_ID_EXE,
    input  logic [WIDTH-1:0] b_ID_EXE,
    output logic             stall_req,
    output logic             busy,
    output logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_rdata
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;

    logic [5:0]         funct;
    logic               special;
    logic               is_mfhi;
    logic               is_mflo;
    logic               is_mthi;
    logic               is_mtlo;
    logic               is_md;
    logic               is_sgn;
    logic               is_dv;
    logic               hilo_ins;
    logic               idle;
    logic               start;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] res;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;
    logic               unused_ins;

    assign funct      = ins_ID_EXE[5:0];
    assign special    = ins_ID_EXE[31:26] == OP_SPECIAL;
    assign unused_ins = ^ins_ID_EXE[25:6];

    always_comb begin
        is_mfhi = special && funct == F_MFHI;
        is_mflo = special && funct == F_MFLO;
        is_mthi = special && funct == F_MTHI;
        is_mtlo = special && funct == F_MTLO;
        is_sgn  = special && (funct == F_MULT || funct == F_DIV);
        is_dv   = special && (funct == F_DIV || funct == F_DIVU);
        is_md   = special && (funct == F_MULT || funct == F_MULTU ||
                              funct == F_DIV  || funct == F_DIVU);
        hilo_ins = is_md || is_mfhi || is_mflo || is_mthi || is_mtlo;
    end

    assign idle      = state == IDLE;
    assign busy      = !idle;
    assign stall_req = busy && hilo_ins;
    assign start     = idle && is_md;
    assign hilo_sel  = idle && (is_mfhi || is_mflo);

    always_comb begin
        hilo_rdata = '0;
        if (idle && is_mfhi)
            hilo_rdata = hi;
        else if (idle && is_mflo)
            hilo_rdata = lo;
    end

    assign a_abs = (is_sgn && a_ID_EXE[WIDTH-1]) ? -a_ID_EXE : a_ID_EXE;
    assign b_abs = (is_sgn && b_ID_EXE[WIDTH-1]) ? -b_ID_EXE : b_ID_EXE;

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clock  (clock),
        .reset  (reset),
        .op_div (is_dv),
        .load   (start),
        .step   (state == RUN),
        .a      (a_abs),
        .b      (b_abs),
        .res    (res)
    );

    // With a zero divisor the engine leaves |dividend| as remainder, so
    // re-applying the dividend sign returns the original dividend.
    always_comb begin
        prod  = neg_q ? -res : res;
        fix_r = neg_r ? -res[2*WIDTH-1:WIDTH] : res[2*WIDTH-1:WIDTH];
        if (b_zero)
            fix_q = DIV0_Q[WIDTH-1:0];
        else
            fix_q = neg_q ? -res[WIDTH-1:0] : res[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_div <= is_dv;
                        neg_q  <= is_sgn &&
                                  (a_ID_EXE[WIDTH-1] ^ b_ID_EXE[WIDTH-1]);
                        neg_r  <= is_sgn && a_ID_EXE[WIDTH-1];
                        b_zero <= is_dv && b_ID_EXE == '0;
                        count  <= '0;
                        state  <= RUN;
                    end else begin
                        if (is_mthi) hi <= a_ID_EXE;
                        if (is_mtlo) lo <= a_ID_EXE;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    if (op_div) begin
                        hi <= fix_r;
                        lo <= fix_q;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: directed cases plus random ops checked
// against an arithmetic reference of HI/LO.
module tb_exe_muldiv;
    import exe_muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ins = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall_req;
    logic        busy;
    logic        hilo_sel;
    logic [31:0] hilo_rdata;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    exe_muldiv dut (
        .clock      (clock),
        .reset      (reset),
        .ins_ID_EXE (ins),
        .a_ID_EXE   (a),
        .b_ID_EXE   (b),
        .stall_req  (stall_req),
        .busy       (busy),
        .hilo_sel   (hilo_sel),
        .hilo_rdata (hilo_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (hilo_sel === 1'b1) begin
            if (exp_q.size() == 0)
                check("unexpected_read", hilo_rdata, 32'hxxxxxxxx);
            else
                check("hilo_rdata", hilo_rdata, exp_q.pop_front());
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    task automatic model(input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y);
        longint p;
        logic [63:0] pu;
        int q;
        int r;
        case (f)
            F_MULT: begin
                p = longint'($signed(x)) * longint'($signed(y));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            F_MULTU: begin
                pu = {32'd0, x} * {32'd0, y};
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            F_DIV: begin
                if (y == 0) begin
                    m_lo = 32'hFFFFFFFF;
                    m_hi = x;
                end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    m_lo = 32'h80000000;
                    m_hi = 0;
                end else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    m_lo = q;
                    m_hi = r;
                end
            end
            F_DIVU: begin
                if (y == 0) begin
                    m_lo = 32'hFFFFFFFF;
                    m_hi = x;
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            F_MTHI: m_hi = x;
            F_MTLO: m_lo = x;
            default: ;
        endcase
    endtask

    // Present an instruction, hold it through any stall, return after
    // the edge that consumed it.
    task automatic issue(input logic [31:0] i, input logic [31:0] x,
                         input logic [31:0] y, output int stalls,
                         output int sel_bad);
        ins = i;
        a = x;
        b = y;
        stalls = 0;
        sel_bad = 0;
        @(negedge clock);
        while (stall_req && stalls < 200) begin
            stalls++;
            if (hilo_sel) sel_bad++;
            @(negedge clock);
        end
        if (stalls >= 200) check("issue_timeout", 32'(stalls), 0);
        @(posedge clock);
        #1;
        ins = '0;
    endtask

    task automatic op(input logic [5:0] f, input logic [31:0] x,
                      input logic [31:0] y, output int stalls);
        int bad;
        model(f, x, y);
        issue(mk(f), x, y, stalls, bad);
    endtask

    task automatic mf(input logic [5:0] f, input logic [31:0] e);
        int s;
        int bad;
        exp_q.push_back(e);
        issue(mk(f), 0, 0, s, bad);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        @(negedge clock);
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic directed(input logic [5:0] f, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] ehi,
                            input logic [31:0] elo);
        int s;
        op(f, x, y, s);
        mf(F_MFHI, ehi);
        mf(F_MFLO, elo);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp[4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1};
        if ($urandom_range(3) == 0) return sp[$urandom_range(3)];
        return $urandom;
    endfunction

    initial begin
        int s;
        int bad;
        int n;
        logic [5:0] fl[6] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
        logic [5:0] f;
        logic [31:0] x;
        logic [31:0] y;

        ins = 32'h00000020;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_stall", {31'd0, stall_req}, 0);
        check("rst_sel", {31'd0, hilo_sel}, 0);
        check("rst_rdata", hilo_rdata, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        ins = '0;
        mf(F_MFHI, 32'h0);

        op(F_MULT, 32'hFFFFFFFE, 3, s);
        busy_len(n);
        check("mult_busy_len", 32'(n), 33);
        mf(F_MFHI, 32'hFFFFFFFF);
        mf(F_MFLO, 32'hFFFFFFFA);
        directed(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        directed(F_DIV, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        directed(F_DIVU, 100, 7, 2, 14);
        directed(F_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000);
        directed(F_DIVU, 7, 0, 7, 32'hFFFFFFFF);
        directed(F_DIV, 32'hFFFFFFF9, 0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        op(F_MULT, 6, 7, s);
        @(posedge clock);
        #1;
        exp_q.push_back(42);
        issue(mk(F_MFLO), 0, 0, s, bad);
        check("mflo_stall_cycles", 32'(s), 32);
        check("mflo_sel_during_stall", 32'(bad), 0);

        op(F_DIV, 32'h12345678, 32'hFFFFFF00, s);
        op(F_MULT, 32'h7FFF0001, 32'h80000003, s);
        check("mult_behind_div_stall", 32'(s), 33);
        busy_len(n);
        check("mult_behind_div_busy", 32'(n), 33);
        mf(F_MFHI, m_hi);
        mf(F_MFLO, m_lo);

        op(F_MTHI, 32'h12345678, 0, s);
        check("mthi_stall", 32'(s), 0);
        exp_q.push_back(32'h12345678);
        issue(mk(F_MFHI), 0, 0, s, bad);
        check("mfhi_stall", 32'(s), 0);

        issue({6'h01, 20'd0, F_MTHI}, 32'hDEADBEEF, 0, s, bad);
        ins = {6'h01, 20'd0, F_MFHI};
        @(negedge clock);
        check("foreign_opcode_sel", {31'd0, hilo_sel}, 0);
        @(posedge clock);
        #1;
        mf(F_MFHI, 32'h12345678);

        for (int k = 0; k < 16; k++) begin
            f = fl[$urandom_range(5)];
            x = pick();
            y = pick();
            op(f, x, y, s);
            mf(F_MFHI, m_hi);
            mf(F_MFLO, m_lo);
        end

        op(F_DIVU, 32'hCAFEF00D, 13, s);
        repeat (10) @(posedge clock);
        #1;
        ins = mk(F_MFHI);
        @(negedge clock);
        check("pre_reset_stall", {31'd0, stall_req}, 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        m_hi = 0;
        m_lo = 0;
        exp_q.push_back(0);
        @(negedge clock);
        check("post_reset_busy", {31'd0, busy}, 0);
        check("post_reset_stall", {31'd0, stall_req}, 0);
        @(posedge clock);
        #1;
        ins = '0;
        mf(F_MFLO, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            n++;
            @(posedge clock);
        end
        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Iterative HI/LO multiply/divide unit in the EXE stage of the 5-stage pipeline. It consumes the ID/EXE register outputs: instruction, operand a, operand b. It executes MULT/MULTU/DIV/DIVU over multiple cycles and serves MFHI/MFLO/MTHI/MTLO. It raises a stall request to the hazard unit while a HI/LO access would conflict with an operation in flight.

Parameters:
WIDTH, 32, operand width. Iteration count equals WIDTH. Only 32 is required to be supported.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low
ins_ID_EXE  in  32  instruction in EXE; opcode [31:26], funct [5:0]
a_ID_EXE  in  32  rs value; dividend / multiplicand / MTHI/MTLO data
b_ID_EXE  in  32  rt value; divisor / multiplier
stall_req  out  1  freeze PC, IF/ID and ID/EXE; insert bubble into EXE/MEM
busy  out  1  operation in flight (state != IDLE)
hilo_sel  out  1  EXE result mux selects hilo_rdata (MFHI/MFLO, not stalled)
hilo_rdata  out  32  HI for MFHI, LO for MFLO, else 0

Behaviour:
- Decode: only opcode 6'b000000 is recognised, with these funct values:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - all other instructions are ignored.
- States: IDLE, RUN, FIX.
- IDLE + mul/div in EXE, at edge T:
  - Capture the operands.
  - Signed ops: store absolute values, plus sign flags for the result (a^b) and the remainder (a).
  - count <= 0; state -> RUN. stall_req is 0 in that cycle, so the pipeline advances.
- RUN: one radix-2 step per edge.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
  - count increments; after the 32nd step (count==31 at the edge) state -> FIX.
- FIX, one edge:
  - Apply sign correction.
  - Write HI/LO: mul gives HI=product[63:32], LO=product[31:0]; div gives LO=quotient, HI=remainder.
  - state -> IDLE.
- busy is high for exactly 33 cycles after edge T. HI/LO are updated at edge T+33.
- stall_req (combinational) = busy AND EXE instruction is any of the eight HI/LO funct codes. While stalled, the unit ignores the instruction. The held instruction re-evaluates each cycle and proceeds in the first IDLE cycle.
- A mul/div arriving while busy therefore stalls, then starts once the unit returns to IDLE.
- MTHI/MTLO in IDLE: HI/LO <= a_ID_EXE at that edge. A following MFHI/MFLO reads the new value (no bypass needed).
- MFHI/MFLO in IDLE: hilo_sel=1; hilo_rdata = current HI/LO, combinational.
- Divide by zero:
  - quotient = 0xFFFFFFFF, remainder = dividend.
  - Applies to DIV and DIVU.
  - The sign fixup is skipped for DIV.
- Signed overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Reset low (any state, including mid-operation):
  - At the next edge: state=IDLE, HI=LO=0, count=0, accumulators 0.
  - The in-flight operation is discarded.
  - Outputs after reset: busy=0, stall_req=0, hilo_sel=0, hilo_rdata=0 (for a non-HI/LO instruction).

Decomposition:
- Shared package: opcode SPECIAL, the eight funct constants, state encoding (IDLE/RUN/FIX), and the divide-by-zero quotient constant.
- One sub-module, muldiv_datapath:
  - holds the 64-bit accumulator and the shift/add/subtract step;
  - interface: op (mul/div), load, step, final-value outputs.
- Top-level exe_muldiv keeps the FSM, counter, HI/LO registers, decode and stall logic.

Test Plan:
1. MULT a=0xFFFFFFFE, b=3 → busy high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
2. DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
3. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0xFFFFFFF9/0 → LO=0xFFFFFFFF, HI=0xFFFFFFF9.
4. MULT 6×7, then MFLO in EXE on the next cycle → stall_req high for 32 cycles, hilo_sel=0. In the first IDLE cycle stall_req=0, hilo_sel=1, hilo_rdata=42.
5. DIV started, then a back-to-back MULT → MULT stalls until IDLE, then starts. Busy stays high for a further 33 cycles; the final HI/LO hold the MULT result.
6. MTHI a=0x12345678 in IDLE, then MFHI → hilo_rdata=0x12345678, no stall. Reset low at RUN step 10 of a DIV → next cycle busy=0, HI=LO=0, stall_req=0.
